accel_fifo: RTL and testbench

Synchronous 128-bit FIFO sitting between the data/control router and one accelerator (FFT, FIR or IIR). One instance serves each direction per accelerator: the to-accelerator side is written by the router and read by the accelerator; the from-accelerator side is the reverse. The block supplies the `*_full` / `*_empty` status that the router uses to throttle its address stream, and it carries the put/get request handshake.

---
 rtl/accel_fifo.sv | 139 +++++++++++++
 tb/tb_accel_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_fifo.sv
// accel_fifo: register-array FIFO between the router and one accelerator.
// Provides registered occupancy/status flags, a registered read port with a
// one-cycle valid pulse, and sticky overflow/underflow error flags.
module accel_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  put_req,
    input  logic [DATA_WIDTH-1:0] put_data,
    input  logic                  get_req,
    output logic [DATA_WIDTH-1:0] get_data,
    output logic                  get_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic [ADDR_WIDTH-1:0] rp_q, rp_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic [DATA_WIDTH-1:0] get_data_q, get_data_d;
    logic                  get_valid_q, get_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  put_acc;
    logic                  get_acc;
    logic                  wr_en;

    // Acceptance is judged against the registered (pre-edge) full/empty flags.
    always_comb begin
        put_acc = put_req && !full_q;
        get_acc = get_req && !empty_q;
        wr_en   = put_acc && !flush;
    end

    // Next-state for pointers, occupancy, flags and the read port; flush wins.
    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        get_data_d  = get_data_q;
        get_valid_d = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (put_acc) begin
                wp_d = wp_q + PTR_ONE;
            end
            if (get_acc) begin
                rp_d        = rp_q + PTR_ONE;
                get_data_d  = mem_q[rp_q];
                get_valid_d = 1'b1;
            end
            case ({put_acc, get_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (put_req && full_q) begin
                ovf_d = 1'b1;
            end
            if (get_req && empty_q) begin
                unf_d = 1'b1;
            end
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
    end

    // Control/status state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            get_data_q  <= '0;
            get_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            get_data_q  <= get_data_d;
            get_valid_q <= get_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage array; contents survive reset and flush, only pointers move.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q] <= put_data;
        end
    end

    assign get_data    = get_data_q;
    assign get_valid   = get_valid_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = af_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_accel_fifo.sv
// Testbench for accel_fifo: constant-expectation vector table plus a
// queue-based reference model and data scoreboard for multi-cycle scenarios.
module tb_accel_fifo;

    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          put_req;
    logic [DW-1:0] put_data;
    logic          get_req;
    logic [DW-1:0] get_data;
    logic          get_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    accel_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (AF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .put_req    (put_req),
        .put_data   (put_data),
        .get_req    (get_req),
        .get_data   (get_data),
        .get_valid  (get_valid),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state and data scoreboard.
    logic [DW-1:0] sbq[$];
    int            m_cnt;
    logic          m_ovf;
    logic          m_unf;
    logic          m_gv;
    logic [DW-1:0] m_gd;

    typedef struct {
        logic          f;
        logic          p;
        logic          g;
        logic [DW-1:0] d;
        int            cnt;
        logic          empty;
        logic          unf;
        logic          gv;
        logic [DW-1:0] gd;
    } vec_t;

    localparam int NV = 10;
    vec_t vt[NV];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_gv  = 1'b0;
        m_gd  = '0;
    endtask

    // One clock cycle: drive, advance the model, wait the edge, compare.
    task automatic cycle(input logic f, input logic p, input logic [DW-1:0] d, input logic g);
        logic pa;
        logic ga;
        flush    = f;
        put_req  = p;
        put_data = d;
        get_req  = g;
        if (f) begin
            sbq.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_gv  = 1'b0;
        end else begin
            pa = p && (m_cnt != DEPTH);
            ga = g && (m_cnt != 0);
            if (p && !pa) m_ovf = 1'b1;
            if (g && !ga) m_unf = 1'b1;
            m_gv = ga;
            if (pa) sbq.push_back(d);
            m_cnt = m_cnt + (pa ? 1 : 0) - (ga ? 1 : 0);
        end
        @(posedge clk);
        #1;
        flush   = 1'b0;
        put_req = 1'b0;
        get_req = 1'b0;
        chkn("count", int'(count), m_cnt);
        chk1("full", full, m_cnt == DEPTH);
        chk1("empty", empty, m_cnt == 0);
        chk1("almost_full", almost_full, m_cnt >= AF);
        chk1("overflow", overflow, m_ovf);
        chk1("underflow", underflow, m_unf);
        chk1("get_valid", get_valid, m_gv);
        if (get_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_pop: got get_valid with data %0h expected no pending word", get_data);
            end else begin
                m_gd = sbq.pop_front();
            end
        end
        chkw("get_data", get_data, m_gd);
    endtask

    task automatic check_reset_values(input string tag);
        chkn({tag, "_count"}, int'(count), 0);
        chk1({tag, "_empty"}, empty, 1'b1);
        chk1({tag, "_full"}, full, 1'b0);
        chk1({tag, "_af"}, almost_full, 1'b0);
        chk1({tag, "_gv"}, get_valid, 1'b0);
        chkw({tag, "_gd"}, get_data, '0);
        chk1({tag, "_ovf"}, overflow, 1'b0);
        chk1({tag, "_unf"}, underflow, 1'b0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          f     p     g     d        cnt empty unf   gv    gd
        vt[0] = '{1'b0, 1'b1, 1'b0, 128'h1,  1, 1'b0, 1'b0, 1'b0, 128'h0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 128'h2,  2, 1'b0, 1'b0, 1'b0, 128'h0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 128'h3,  3, 1'b0, 1'b0, 1'b0, 128'h0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 128'h0,  2, 1'b0, 1'b0, 1'b1, 128'h1};
        vt[4] = '{1'b0, 1'b0, 1'b1, 128'h0,  1, 1'b0, 1'b0, 1'b1, 128'h2};
        vt[5] = '{1'b0, 1'b0, 1'b1, 128'h0,  0, 1'b1, 1'b0, 1'b1, 128'h3};
        vt[6] = '{1'b0, 1'b0, 1'b1, 128'h0,  0, 1'b1, 1'b1, 1'b0, 128'h3};
        vt[7] = '{1'b0, 1'b0, 1'b0, 128'h0,  0, 1'b1, 1'b1, 1'b0, 128'h3};
        vt[8] = '{1'b1, 1'b0, 1'b0, 128'h0,  0, 1'b1, 1'b0, 1'b0, 128'h3};
        vt[9] = '{1'b0, 1'b0, 1'b0, 128'h0,  0, 1'b1, 1'b0, 1'b0, 128'h3};

        reset    = 1'b1;
        flush    = 1'b0;
        put_req  = 1'b0;
        get_req  = 1'b0;
        put_data = '0;
        model_reset();
        #12;
        check_reset_values("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic ordering, underflow on empty, flush clears the error.
        for (int i = 0; i < NV; i++) begin
            cycle(vt[i].f, vt[i].p, vt[i].d, vt[i].g);
            chkn($sformatf("tbl%0d_count", i), int'(count), vt[i].cnt);
            chk1($sformatf("tbl%0d_empty", i), empty, vt[i].empty);
            chk1($sformatf("tbl%0d_unf", i), underflow, vt[i].unf);
            chk1($sformatf("tbl%0d_gv", i), get_valid, vt[i].gv);
            chkw($sformatf("tbl%0d_gd", i), get_data, vt[i].gd);
        end

        // Fill to full, check almost_full threshold, overflow, full drain.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, DW'(32'h100 + i), 1'b0);
            if (i == AF - 2) chk1("af_after_11", almost_full, 1'b0);
            if (i == AF - 1) chk1("af_after_12", almost_full, 1'b1);
        end
        chk1("fill_full", full, 1'b1);
        chkn("fill_count", int'(count), DEPTH);
        cycle(1'b0, 1'b1, DW'(32'hDEAD), 1'b0);
        chk1("ovf_set", overflow, 1'b1);
        chkn("ovf_count", int'(count), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            chkw($sformatf("drain%0d", i), get_data, DW'(32'h100 + i));
        end
        chk1("drain_empty", empty, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0);

        // Put+get while full, then put+get at count 8.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, DW'(32'h200 + i), 1'b0);
        end
        cycle(1'b0, 1'b1, DW'(32'hBEEF), 1'b1);
        chkn("pg_full_count", int'(count), DEPTH - 1);
        chk1("pg_full_ovf", overflow, 1'b1);
        chkw("pg_full_gd", get_data, DW'(32'h200));
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, DW'(32'h300 + i), 1'b1);
            chkn($sformatf("pg8_count%0d", i), int'(count), 8);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
        end
        chkw("pg8_last", get_data, DW'(32'h303));
        cycle(1'b1, 1'b0, '0, 1'b0);

        // Wrap-around: steady interleaved traffic at count 5.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, DW'(32'h400 + i), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, DW'(32'h405 + i), 1'b1);
        end
        chkn("wrap_count", int'(count), 5);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
        end
        chkw("wrap_last", get_data, DW'(32'h42C));
        chk1("wrap_empty", empty, 1'b1);

        // Asynchronous reset mid-cycle at count 7.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, DW'(32'h500 + i), 1'b0);
        end
        chkn("pre_reset_count", int'(count), 7);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        #2;
        reset = 1'b0;
        cycle(1'b0, 1'b1, DW'(32'hA), 1'b0);
        chkn("post_reset_count", int'(count), 1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chkw("post_reset_gd", get_data, DW'(32'hA));
        chk1("post_reset_gv", get_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
